// File: rtl/noc_pkg.sv
// Shared defaults, head-FSM encoding and assertion helpers for the NoC input buffer.
package noc_pkg;

  localparam int NOC_PORTS = 2;
  localparam int NOC_WIDTH = 8;

  // One-hot encoding lets the assertions catch a corrupted state register.
  typedef enum logic [1:0] {
    HEAD_IDLE = 2'b01,
    HEAD_SEND = 2'b10
  } head_state_e;

  function automatic logic onehot_or_zero(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage for the input buffer: one write port plus asynchronous reads
// of the head entry and of the destination mask of the entry behind it.
module noc_fifo_mem #(
  parameter int DEPTH   = 4,
  parameter int PORTS   = 2,
  parameter int ENTRY_W = 10,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic [AW-1:0]      head_addr,
  input  logic [AW-1:0]      next_addr,
  output logic [ENTRY_W-1:0] head_entry,
  output logic [PORTS-1:0]   next_dest
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  // Destination sits in the low bits of each entry.
  assign head_entry = mem[head_addr];
  assign next_dest  = mem[next_addr][PORTS-1:0];

endmodule

// File: rtl/noc_input_buffer.sv
// Per-input flit queue feeding one crossbar row; retires multicast destination
// bits as they are acked. Define NOC_IBUF_STATS_EN to enable the stall counter.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int PORTS = NOC_PORTS,
  parameter int WIDTH = NOC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [PORTS-1:0]         in_dest,
  output logic [WIDTH-1:0]         xbar_data,
  output logic [PORTS-1:0]         xbar_dest,
  input  logic [PORTS-1:0]         xbar_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + PORTS;

  head_state_e      state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PORTS-1:0] pending_q, pending_d;

  logic             full;
  logic             push;
  logic             enq;
  logic             pop;
  logic [PORTS-1:0] remain;
  logic [EW-1:0]    head_entry;
  logic [PORTS-1:0] next_dest;

  assign full   = (count_q == CW'(DEPTH));
  assign push   = in_valid && !full;
  // Flits with no destination are consumed but never stored.
  assign enq    = push && (in_dest != '0);
  assign remain = pending_q & ~xbar_ack;
  assign pop    = (state_q == HEAD_SEND) && (remain == '0);

  noc_fifo_mem #(
    .DEPTH  (DEPTH),
    .PORTS  (PORTS),
    .ENTRY_W(EW),
    .AW     (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en     (enq),
    .wr_addr   (wr_ptr_q),
    .wr_entry  ({in_data, in_dest}),
    .head_addr (rd_ptr_q),
    .next_addr (rd_ptr_q + AW'(1)),
    .head_entry(head_entry),
    .next_dest (next_dest)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(enq) - CW'(pop);
    state_d   = state_q;
    pending_d = pending_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case (state_q)
      HEAD_IDLE: begin
        if (enq) begin
          state_d   = HEAD_SEND;
          pending_d = in_dest;
        end
      end
      HEAD_SEND: begin
        if (!pop) begin
          pending_d = remain;
        end else if (count_q > CW'(1)) begin
          pending_d = next_dest;
        end else if (enq) begin
          // The successor is being written this very edge, so take it from the input.
          pending_d = in_dest;
        end else begin
          state_d   = HEAD_IDLE;
          pending_d = '0;
        end
      end
      default: begin
        state_d   = HEAD_IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HEAD_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign in_ready  = !full;
  assign count     = count_q;
  assign xbar_dest = pending_q;
  assign xbar_data = (state_q == HEAD_SEND) ? head_entry[PORTS +: WIDTH] : '0;

`ifdef NOC_IBUF_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == HEAD_SEND && (xbar_ack & pending_q) == '0 && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  a_ack_in_pending: assert property (@(posedge clk) disable iff (rst)
    (xbar_ack & ~pending_q) == '0)
    else $error("xbar_ack asserted outside pending mask");

  a_state_sane: assert property (@(posedge clk) disable iff (rst)
    onehot_or_zero(32'(state_q)) && (count_q <= CW'(DEPTH)))
    else $error("head state or count corrupted");

endmodule

// File: tb/tb_noc_input_buffer.sv
// Randomized self-checking bench for noc_input_buffer against a queue-based
// reference model; honours NOC_IBUF_STATS_EN for the stall counter.
module tb_noc_input_buffer;

  localparam int PORTS = 2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

`ifdef NOC_IBUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [PORTS-1:0] in_dest;
  logic [WIDTH-1:0] xbar_data;
  logic [PORTS-1:0] xbar_dest;
  logic [PORTS-1:0] xbar_ack;
  logic [2:0]       count;
  logic [15:0]      stall_cnt;

  noc_input_buffer #(.PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .xbar_data(xbar_data),
    .xbar_dest(xbar_dest),
    .xbar_ack (xbar_ack),
    .count    (count),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [PORTS-1:0] dest;
  } flit_t;

  flit_t            mq[$];
  logic [PORTS-1:0] m_pend;
  int               m_stall;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    check("count", 32'(count), 32'(mq.size()));
    check("xbar_dest", 32'(xbar_dest), 32'(m_pend));
    check("xbar_data", 32'(xbar_data), (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then compare.
  task automatic tick(input logic v, input logic [WIDTH-1:0] d,
                      input logic [PORTS-1:0] dst, input logic [PORTS-1:0] ack_req);
    logic [PORTS-1:0] a;
    bit acc, popd, was_empty;
    a        = ack_req & m_pend;
    in_valid = v;
    in_data  = d;
    in_dest  = dst;
    xbar_ack = a;
    was_empty = (mq.size() == 0);
    acc       = v && (mq.size() < DEPTH);
    popd      = !was_empty && ((m_pend & ~a) == '0);
    if (STATS && !was_empty && (a & m_pend) == '0 && m_stall < 65535) m_stall++;
    if (popd) begin
      $display("[TB] pop  data=%h", mq[0].data);
      void'(mq.pop_front());
    end
    if (acc && dst != '0) begin
      $display("[TB] push data=%h dest=%b", d, dst);
      mq.push_back('{data: d, dest: dst});
    end
    if (popd || was_empty) m_pend = (mq.size() != 0) ? mq[0].dest : '0;
    else                   m_pend = m_pend & ~a;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset applied between edges, checked before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    xbar_ack = '0;
    rst      = 1'b1;
    #1;
    mq.delete();
    m_pend  = '0;
    m_stall = 0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_dest", 32'(xbar_dest), 32'd0);
    check("rst_data", 32'(xbar_data), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    xbar_ack = '0;
    m_pend   = '0;
    m_stall  = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Unicast single flit
    tick(1'b1, 8'hA5, 2'b01, 2'b00);
    check("t1_data", 32'(xbar_data), 32'hA5);
    check("t1_count", 32'(count), 32'd1);
    tick(1'b0, 8'h00, 2'b00, 2'b01);
    check("t1_empty", 32'(count), 32'd0);

    // Multicast served over two cycles
    do_reset();
    tick(1'b1, 8'h3C, 2'b11, 2'b00);
    check("t2_dest0", 32'(xbar_dest), 32'h3);
    tick(1'b0, 8'h00, 2'b00, 2'b01);
    check("t2_dest1", 32'(xbar_dest), 32'h2);
    tick(1'b0, 8'h00, 2'b00, 2'b10);
    check("t2_count", 32'(count), 32'd0);
    check("t2_stall", 32'(stall_cnt), 32'd0);

    // Fill to full, refuse a fifth, drain with wrap
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h10 + i), 2'b01, 2'b00);
    check("t3_full_cnt", 32'(count), 32'd4);
    check("t3_ready", 32'(in_ready), 32'd0);
    tick(1'b1, 8'hEE, 2'b01, 2'b00);
    check("t3_no_accept", 32'(count), 32'd4);
    for (int i = 0; i < 10; i++) tick(i < 4, 8'(8'h20 + i), 2'b10, 2'b11);

    // Simultaneous push and pop, then a zero-destination flit
    do_reset();
    tick(1'b1, 8'h41, 2'b01, 2'b00);
    tick(1'b1, 8'h42, 2'b01, 2'b00);
    tick(1'b1, 8'h43, 2'b10, 2'b01);
    check("t4_pushpop", 32'(count), 32'd2);
    tick(1'b1, 8'h44, 2'b00, 2'b00);
    check("t4_zero_dest", 32'(count), 32'd2);

    // Head blocked for ten cycles
    do_reset();
    tick(1'b1, 8'h5A, 2'b10, 2'b00);
    for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 2'b00, 2'b00);
    check("t5_stall", 32'(stall_cnt), STATS ? 32'd10 : 32'd0);
    tick(1'b0, 8'h00, 2'b00, 2'b10);

    // Reset during a partially served multicast
    do_reset();
    tick(1'b1, 8'h11, 2'b11, 2'b00);
    tick(1'b1, 8'h22, 2'b01, 2'b01);
    tick(1'b1, 8'h33, 2'b10, 2'b00);
    check("t6_pre_cnt", 32'(count), 32'd3);
    check("t6_pre_dest", 32'(xbar_dest), 32'h2);
    do_reset();
    tick(1'b0, 8'h00, 2'b00, 2'b00);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
